// File: rtl/ffs_pkg.sv
// Shared types and defaults for the find-first-set sequencer.
package ffs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int LOC_W_DEF = 16;

endpackage

// File: rtl/ffs_sequencer_if.sv
// Vector-in / location-out handshake bundle for ffs_sequencer.
interface ffs_sequencer_if
    import ffs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOC_W = LOC_W_DEF
) ();

    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] vector;
    logic             out_vld;
    logic             out_rdy;
    logic [LOC_W-1:0] location;
    logic             last;
    logic             empty;

    modport master (
        output in_vld, vector, out_rdy,
        input  in_rdy, out_vld, location, last, empty
    );

    modport slave (
        input  in_vld, vector, out_rdy,
        output in_rdy, out_vld, location, last, empty
    );

endinterface

// File: rtl/ffs_msb_comb.sv
// Combinational priority encoder: index of the highest set bit plus any/single flags.
module ffs_msb_comb #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_single
);

    // Ascending scan: the last set bit seen wins, and single drops on any second hit.
    always_comb begin
        o_idx    = '0;
        o_any    = 1'b0;
        o_single = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_idx    = IDX_W'(i);
                o_single = !o_any;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ffs_sequencer.sv
// Serialises the set bits of an accepted vector as location beats, highest index first.
//
// state | meaning
// IDLE  | in_rdy high, waiting for a vector
// EMIT  | out_vld high, presenting highest remaining bit of the pending register
module ffs_sequencer
    import ffs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOC_W = LOC_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    ffs_sequencer_if.slave bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_clear_mask;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic             w_out_vld_nxt;
    logic [LOC_W-1:0] r_location;
    logic [LOC_W-1:0] w_location_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_empty;
    logic             w_empty_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_single;

    // Encoding the next pending value lets location/last be registered outputs.
    ffs_msb_comb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_msb (
        .i_vec    (w_pending_nxt),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_single (w_single)
    );

    assign w_clear_mask = {{(WIDTH-1){1'b0}}, 1'b1} << r_location;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_out_vld_nxt = r_out_vld;
        w_empty_nxt   = r_empty;
        if (flush) begin
            w_state_nxt   = IDLE;
            w_pending_nxt = '0;
            w_out_vld_nxt = 1'b0;
            w_empty_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_vld && r_in_rdy) begin
                        w_state_nxt   = EMIT;
                        w_pending_nxt = bus.vector;
                        w_out_vld_nxt = 1'b1;
                        w_empty_nxt   = (bus.vector == '0);
                    end
                end
                EMIT: begin
                    if (bus.out_rdy) begin
                        if (r_last) begin
                            w_state_nxt   = IDLE;
                            w_pending_nxt = '0;
                            w_out_vld_nxt = 1'b0;
                            w_empty_nxt   = 1'b0;
                        end else begin
                            w_pending_nxt = r_pending & ~w_clear_mask;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_pending_nxt = '0;
                    w_out_vld_nxt = 1'b0;
                    w_empty_nxt   = 1'b0;
                end
            endcase
        end
    end

    // An all-zero pending register still yields one beat, so it counts as last.
    always_comb begin
        w_location_nxt = '0;
        w_last_nxt     = 1'b0;
        if (w_out_vld_nxt) begin
            w_location_nxt = LOC_W'(w_idx);
            w_last_nxt     = w_single || !w_any;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_in_rdy   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_location <= '0;
            r_last     <= 1'b0;
            r_empty    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_in_rdy   <= (w_state_nxt == IDLE);
            r_out_vld  <= w_out_vld_nxt;
            r_location <= w_location_nxt;
            r_last     <= w_last_nxt;
            r_empty    <= w_empty_nxt;
        end
    end

    assign bus.in_rdy   = r_in_rdy;
    assign bus.out_vld  = r_out_vld;
    assign bus.location = r_location;
    assign bus.last     = r_last;
    assign bus.empty    = r_empty;

endmodule

// File: tb/tb_ffs_sequencer.sv
// Directed plus randomized bench for ffs_sequencer against a queue-of-indices reference model.
module tb_ffs_sequencer;
    import ffs_pkg::*;

    localparam int WIDTH = 8;
    localparam int LOC_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ffs_sequencer_if #(.WIDTH(WIDTH), .LOC_W(LOC_W)) bus ();

    ffs_sequencer #(.WIDTH(WIDTH), .LOC_W(LOC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a vector becomes the list of its set-bit indices, highest first;
    // an all-zero vector becomes a single empty beat at location 0.
    task automatic run_vector(input logic [WIDTH-1:0] v, input int stall_pct, input int init_stall);
        int   exp_q[$];
        int   nbeats;
        int   cyc;
        logic took;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i]) exp_q.push_back(i);
        if (v == '0) exp_q.push_back(0);
        nbeats = exp_q.size();
        cyc = 0;
        while (bus.in_rdy !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("in_rdy_before_accept", 32'(bus.in_rdy), 32'd1);
        bus.in_vld  = 1'b1;
        bus.vector  = v;
        bus.out_rdy = 1'($urandom_range(0, 1));
        tick();
        bus.in_vld = 1'b0;
        bus.vector = WIDTH'($urandom);
        check("accept_latency", 32'(bus.out_vld), 32'd1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            check("out_vld", 32'(bus.out_vld), 32'd1);
            check("in_rdy_emit", 32'(bus.in_rdy), 32'd0);
            check("location", 32'(bus.location), exp_q[0]);
            check("last", 32'(bus.last), 32'(exp_q.size() == 1));
            check("empty", 32'(bus.empty), 32'(v == '0));
            took = (cyc >= init_stall) && ($urandom_range(0, 99) >= stall_pct);
            bus.out_rdy = took;
            bus.in_vld  = 1'($urandom_range(0, 1));
            bus.vector  = WIDTH'($urandom);
            tick();
            cyc++;
            if (took) void'(exp_q.pop_front());
        end
        check("beats_done", exp_q.size(), 32'd0);
        if (stall_pct == 0) check("beat_cycles", cyc, nbeats + init_stall);
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        check("out_vld_after_last", 32'(bus.out_vld), 32'd0);
        check("in_rdy_after_last", 32'(bus.in_rdy), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_vld  = 1'b0;
        bus.vector  = '0;
        bus.out_rdy = 1'b0;

        // Reset values, including in_rdy low while reset is held.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("rst_location", 32'(bus.location), 32'd0);
        check("rst_last", 32'(bus.last), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("post_rst_out_vld", 32'(bus.out_vld), 32'd0);

        run_vector(8'b1010_0100, 0, 0);
        run_vector(8'h00, 0, 0);
        run_vector(8'b0001_1000, 0, 3);
        run_vector(8'hFF, 0, 0);
        run_vector(8'h01, 0, 0);
        run_vector(8'h80, 50, 0);

        // Flush beats a same-cycle offer in IDLE.
        bus.in_vld = 1'b1;
        bus.vector = 8'h5A;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        bus.in_vld = 1'b0;
        check("flush_idle_out_vld", 32'(bus.out_vld), 32'd0);
        check("flush_idle_in_rdy", 32'(bus.in_rdy), 32'd1);

        // Flush after the first beat of 8'hC3.
        bus.in_vld = 1'b1;
        bus.vector = 8'hC3;
        tick();
        bus.in_vld = 1'b0;
        check("c3_first_loc", 32'(bus.location), 32'd7);
        bus.out_rdy = 1'b1;
        tick();
        check("c3_second_loc", 32'(bus.location), 32'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_out_vld", 32'(bus.out_vld), 32'd0);
        check("flush_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("flush_location", 32'(bus.location), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_more_beats", 32'(bus.out_vld), 32'd0);
        end
        bus.out_rdy = 1'b0;

        // Reset with flush mid-EMIT of 8'h81.
        bus.in_vld = 1'b1;
        bus.vector = 8'h81;
        tick();
        bus.in_vld = 1'b0;
        check("h81_first_loc", 32'(bus.location), 32'd7);
        bus.out_rdy = 1'b1;
        tick();
        check("h81_second_loc", 32'(bus.location), 32'd0);
        check("h81_second_last", 32'(bus.last), 32'd1);
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        check("midrst_out_vld", 32'(bus.out_vld), 32'd0);
        check("midrst_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("midrst_location", 32'(bus.location), 32'd0);
        check("midrst_last", 32'(bus.last), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd0);
        rst_n = 1'b1;
        flush = 1'b0;
        tick();
        check("midrst_release_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("midrst_release_out_vld", 32'(bus.out_vld), 32'd0);
        tick();
        check("midrst_no_beat", 32'(bus.out_vld), 32'd0);
        bus.out_rdy = 1'b0;

        for (int n = 0; n < 30; n++) begin
            run_vector(WIDTH'($urandom), ((n % 3) == 0) ? 0 : int'($urandom_range(0, 60)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ffs_sequencer.md
FFS_SEQUENCER -- requirements
Module: ffs_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning width of the request vector (legal 2..256).
REQ-002 SHALL provide parameter LOC_W, default 16, meaning width of the location output.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current vector.
REQ-006 SHALL have port in_vld  input  1  vector offered.
REQ-007 SHALL have port in_rdy  output  1  sequencer can accept a vector.
REQ-008 SHALL have port vector  input  WIDTH  request bits to be served.
REQ-009 SHALL have port out_vld  output  1  location beat valid.
REQ-010 SHALL have port out_rdy  input  1  consumer accepts beat.
REQ-011 SHALL have port location  output  LOC_W  index of highest remaining set bit.
REQ-012 SHALL have port last  output  1  final beat for the current vector.
REQ-013 SHALL have port empty  output  1  accepted vector was all-zero.

Function
REQ-014 SHALL implement states IDLE, EMIT; in_rdy = (state == IDLE), registered, no combinational in-to-out path.
REQ-015 SHALL accept a vector when in_vld && in_rdy, latch it into a pending register, and go to EMIT.
REQ-016 SHALL assert out_vld the cycle after acceptance (latency 1) and hold it until the last beat is accepted.
REQ-017 SHALL drive location with the index of the highest set bit of the pending register, zero-extended to LOC_W.
REQ-018 SHALL, on a beat transfer (out_vld && out_rdy), clear that bit in the pending register; the next beat's location is valid the following cycle.
REQ-019 SHALL hold location, last, empty stable while out_vld && !out_rdy.
REQ-020 SHALL assert last when the pending register has exactly one set bit.
REQ-021 SHALL, for an all-zero vector, emit exactly one beat with empty=1, last=1, location=0.
REQ-022 SHALL return to IDLE on the transfer of a last beat; in_rdy asserts the next cycle (no back-to-back accept in the same cycle).
REQ-023 SHALL sustain one beat per cycle when out_rdy is held high.
REQ-024 SHALL, on flush, go to IDLE, clear the pending register, and deassert out_vld next cycle; flush has priority over acceptance and transfer in the same cycle.
REQ-025 SHALL ignore in_vld and vector while in EMIT.
REQ-026 SHALL handle all-ones vector: WIDTH beats, locations WIDTH-1 down to 0, last on location 0.

Reset
REQ-027 SHALL on rst_n low: state=IDLE, pending=0, out_vld=0, in_rdy=0 during reset then 1 the first cycle after, location=0, last=0, empty=0.
REQ-028 SHALL treat reset mid-EMIT identically to REQ-027, discarding the pending vector with no further beats.
REQ-029 SHALL give rst_n priority over flush.

Structure
REQ-030 SHALL place the state enum typedef and LOC_W default in shared package ffs_pkg.
REQ-031 SHALL use one combinational sub-module ffs_msb_comb (WIDTH in; index, any-set, single-bit flags out) for priority encoding.
REQ-032 SHALL register all outputs; no latches.

Verification
REQ-033 SHALL cover vector=8'b1010_0100, out_rdy=1 -> locations 7,5,2 on consecutive cycles, last on 2, then in_rdy=1.
REQ-034 SHALL cover vector=8'h00 -> single beat location=0, empty=1, last=1.
REQ-035 SHALL cover vector=8'b0001_1000 with out_rdy low 3 cycles -> location=4 held stable, then 4,3 after release.
REQ-036 SHALL cover vector=8'hFF, out_rdy=1 -> 8 beats 7..0, last only on 0, 8 consecutive cycles.
REQ-037 SHALL cover flush asserted after first beat of 8'hC3 -> out_vld=0 next cycle, no beat for 1 or 0, in_rdy=1.
REQ-038 SHALL cover rst_n low mid-EMIT of 8'h81 with flush also high -> all outputs reset per REQ-027, no beat for 0.
